// File: rtl/alu_pkg.sv
// Shared opcode encoding and constants for the registered ALU.
// Optional barrel shifter is enabled by defining ALU_SHIFT_EN.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_NOR  = 4'b1100
  } alu_op_e;

  localparam int ALU_SHAMT_W = 5;

endpackage

// File: rtl/alu_suma_c2.sv
// WIDTH-bit two's-complement adder/subtractor shared by ADD, SUB, SLT and SLTU.
// Subtraction is a + ~b + 1, so cout=1 means no borrow.
module suma_c2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] bEff;

  assign bEff = b ^ {WIDTH{sub}};
  assign {cout, sum} = {1'b0, a} + {1'b0, bEff} + {{WIDTH{1'b0}}, sub};
  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf = (a[WIDTH-1] == bEff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// Registered ALU: combinational result mux feeding result/carry/zero registers.
// Define ALU_SHIFT_EN to build the SLL/SRL/SRA barrel shifter.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             coutfin,
  output logic             z
);

  alu_op_e          op;
  logic             addSub;
  logic [WIDTH-1:0] addSum;
  logic             addCout;
  logic             addOvf;
  logic [WIDTH-1:0] aluOut_d, aluOut_q;
  logic             cout_d, cout_q;
  logic             z_d, z_q;

  assign op     = alu_op_e'(ALU_Sel);
  assign addSub = (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);

  suma_c2 #(.WIDTH(WIDTH)) uSuma (
    .a    (A),
    .b    (B),
    .sub  (addSub),
    .sum  (addSum),
    .cout (addCout),
    .ovf  (addOvf)
  );

`ifdef ALU_SHIFT_EN
  logic [ALU_SHAMT_W-1:0] shamt;
  assign shamt = B[ALU_SHAMT_W-1:0];
`endif

  always_comb begin
    aluOut_d = '0;
    cout_d   = 1'b0;
    unique case (op)
      ALU_AND:  aluOut_d = A & B;
      ALU_OR:   aluOut_d = A | B;
      ALU_XOR:  aluOut_d = A ^ B;
      ALU_NOR:  aluOut_d = ~(A | B);
      ALU_ADD, ALU_SUB: begin
        aluOut_d = addSum;
        cout_d   = addCout;
      end
      // Signed less-than is the difference's sign corrected for overflow.
      ALU_SLT:  aluOut_d = {{(WIDTH-1){1'b0}}, addSum[WIDTH-1] ^ addOvf};
      ALU_SLTU: aluOut_d = {{(WIDTH-1){1'b0}}, ~addCout};
`ifdef ALU_SHIFT_EN
      ALU_SLL:  aluOut_d = A << shamt;
      ALU_SRL:  aluOut_d = A >> shamt;
      ALU_SRA:  aluOut_d = $unsigned($signed(A) >>> shamt);
`endif
      default:  aluOut_d = '0;
    endcase
    z_d = (aluOut_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluOut_q <= '0;
      cout_q   <= 1'b0;
      z_q      <= 1'b1;
    end else begin
      aluOut_q <= aluOut_d;
      cout_q   <= cout_d;
      z_q      <= z_d;
    end
  end

  assign ALU_Out = aluOut_q;
  assign coutfin = cout_q;
  assign z       = z_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected results are queued at drive time and
// popped after the following rising edge.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALU_Sel;
  logic [31:0] ALU_Out;
  logic        coutfin;
  logic        z;

  int checks;
  int errors;

  typedef struct {
    string       tag;
    logic [31:0] out;
    logic        c;
    logic        zf;
  } exp_t;

  exp_t expQ[$];

  alu #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .ALU_Sel (ALU_Sel),
    .ALU_Out (ALU_Out),
    .coutfin (coutfin),
    .z       (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference model using widened arithmetic.
  function automatic exp_t model(input string tag, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] sel);
    exp_t e;
    logic [32:0] wide;
    e.tag = tag;
    e.out = 32'h0;
    e.c   = 1'b0;
    case (sel)
      4'b0000: e.out = a & b;
      4'b0001: e.out = a | b;
      4'b0010: begin wide = {1'b0, a} + {1'b0, b}; e.out = wide[31:0]; e.c = wide[32]; end
      4'b0011: e.out = a ^ b;
      4'b0110: begin e.out = a - b; e.c = (a >= b); end
      4'b0111: e.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1001: e.out = (a < b) ? 32'd1 : 32'd0;
      4'b1100: e.out = ~(a | b);
`ifdef ALU_SHIFT_EN
      4'b0100: e.out = a << b[4:0];
      4'b0101: e.out = a >> b[4:0];
      4'b1000: e.out = $unsigned($signed(a) >>> b[4:0]);
`endif
      default: e.out = 32'h0;
    endcase
    e.zf = (e.out == 32'h0);
    return e;
  endfunction

  task automatic applyStimulus(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] sel);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    ALU_Sel = sel;
    expQ.push_back(model(tag, a, b, sel));
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput({e.tag, "_out"}, ALU_Out, e.out);
      checkOutput({e.tag, "_cout"}, {31'd0, coutfin}, {31'd0, e.c});
      checkOutput({e.tag, "_z"}, {31'd0, z}, {31'd0, e.zf});
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_out"}, ALU_Out, 32'h0);
    checkOutput({tag, "_cout"}, {31'd0, coutfin}, 32'd0);
    checkOutput({tag, "_z"}, {31'd0, z}, 32'd1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    A       = 32'h0;
    B       = 32'h0;
    ALU_Sel = 4'b0000;

    // Asynchronous reset asserted between edges takes effect at once.
    #2 rst = 1'b1;
    #1 checkReset("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    applyStimulus("add",       32'hABCDEFFF, 32'h12345678, 4'b0010);
    applyStimulus("and",       32'hABCDEFFF, 32'h12345678, 4'b0000);
    applyStimulus("sub",       32'hABCDEFFF, 32'h12345678, 4'b0110);
    applyStimulus("sub_swap",  32'h12345678, 32'hABCDEFFF, 4'b0110);
    applyStimulus("sub_zero",  32'h00000005, 32'h00000005, 4'b0110);
    applyStimulus("add_wrap",  32'hFFFFFFFF, 32'h00000001, 4'b0010);
    applyStimulus("slt",       32'hFFFFFFFF, 32'h00000001, 4'b0111);
    applyStimulus("sltu",      32'hFFFFFFFF, 32'h00000001, 4'b1001);
    applyStimulus("slt_ovf",   32'h80000000, 32'h00000001, 4'b0111);
    applyStimulus("slt_pos",   32'h7FFFFFFF, 32'h80000000, 4'b0111);
    applyStimulus("or",        32'hF0F00000, 32'h000F0F0F, 4'b0001);
    applyStimulus("xor",       32'hFFFF0000, 32'hFF00FF00, 4'b0011);
    applyStimulus("nor",       32'h0F0F0F0F, 32'h30303030, 4'b1100);
    applyStimulus("sra",       32'h80000000, 32'h00000004, 4'b1000);
    applyStimulus("srl",       32'h80000000, 32'h00000004, 4'b0101);
    applyStimulus("sll",       32'h00000003, 32'h0000001F, 4'b0100);
    applyStimulus("undef_a",   32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1010);
    applyStimulus("undef_f",   32'h12345678, 32'h1, 4'b1111);

    // Mid-stream reset discards whatever was registered.
    applyStimulus("pre_rst",   32'h00000010, 32'h00000020, 4'b0010);
    #2 rst = 1'b1;
    #1 checkReset("reset_mid");
    @(negedge clk) rst = 1'b0;
    applyStimulus("post_rst",  32'h00000001, 32'h00000002, 4'b0010);

    for (int i = 0; i < 60; i++) begin
      applyStimulus($sformatf("rnd%0d", i), $urandom, $urandom,
                    4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

32-bit registered arithmetic-logic unit for the datapath execute stage. It selects one of a fixed set of integer operations on operands `A` and `B` using a 4-bit opcode. The result, adder carry-out and zero flag are registered together, so they appear one clock later. Add and subtract share a single two's-complement adder.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width in bits.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `A`: input, WIDTH bits. Operand A.
- `B`: input, WIDTH bits. Operand B.
- `ALU_Sel`: input, 4 bits. Operation select.
- `ALU_Out`: output, WIDTH bits. Registered result.
- `coutfin`: output, 1 bit. Registered adder carry-out.
- `z`: output, 1 bit. Registered zero flag.

## Operation
`ALU_Sel` encoding (result before the register):
- `0000` AND: `A & B`
- `0001` OR: `A | B`
- `0010` ADD: `A + B`
- `0011` XOR: `A ^ B`
- `0100` SLL: `A << B[4:0]`
- `0101` SRL: `A >> B[4:0]`, logical shift
- `0110` SUB: `A + ~B + 1`
- `0111` SLT: 1 if A < B as signed numbers, otherwise 0
- `1000` SRA: `A >>> B[4:0]`, arithmetic shift
- `1001` SLTU: 1 if A < B as unsigned numbers, otherwise 0
- `1100` NOR: `~(A | B)`
- All other codes: result is 0.

Arithmetic and flag rules:
- All arithmetic is modulo 2^WIDTH; overflow is silently discarded.
- `coutfin`:
  - ADD: carry out of bit WIDTH-1.
  - SUB: carry out of `A + ~B + 1`, so 1 means no borrow (A ≥ B unsigned).
  - All other opcodes: 0.
- SLT and SLTU compute the difference with the same adder; SLT uses the sign bit XOR overflow.
- `z` = 1 exactly when the result being registered equals 0. It is computed from the same result, not from the previous `ALU_Out`.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge N appear on `ALU_Out`, `coutfin` and `z` after edge N.
- Throughput is one operation per cycle. There is no handshake and no stall.
- While `rst` is high, outputs hold their reset values immediately, regardless of `clk`: `ALU_Out`=0, `coutfin`=0, `z`=1.
- Asserting `rst` mid-stream discards the in-flight result. The first edge after `rst` falls samples the current inputs normally.
- Changing `ALU_Sel` between edges has no visible effect until the next edge.

## Configuration
- Macro `ALU_SHIFT_EN`.
- Defined: SLL, SRL and SRA are implemented as specified, using a barrel shifter.
- Undefined: opcodes `0100`, `0101` and `1000` produce result 0 with `coutfin`=0 and `z`=1, and no shifter logic is synthesized.

## Structure
- Package `alu_pkg` holds:
  - typedef enum `alu_op_e` (4 bits) with the opcode values above;
  - constant `ALU_SHAMT_W` = 5.
- Sub-module `suma_c2`: a WIDTH-bit two's-complement adder/subtractor.
  - Inputs: `a`, `b`, `sub`.
  - Outputs: `sum`, `cout`, `ovf`.
  - One instance is shared by ADD, SUB, SLT and SLTU.
- The top level contains the result mux (combinational) and the output registers.

## Test plan
- Reset: assert `rst` asynchronously between clock edges → immediately `ALU_Out`=0, `coutfin`=0, `z`=1.
- ADD: A=`ABCDEFFF`, B=`12345678`, `ALU_Sel`=`0010` → after the next edge `ALU_Out`=`BE024677`, `coutfin`=0, `z`=0.
- AND: same operands, `ALU_Sel`=`0000` → `ALU_Out`=`02044678`, `coutfin`=0.
- SUB:
  - A=`ABCDEFFF`, B=`12345678`, `ALU_Sel`=`0110` → `ALU_Out`=`99999987`, `coutfin`=1.
  - Operands swapped → `ALU_Out`=`66666679`, `coutfin`=0.
- Zero and carry: A=B=`00000005`, SUB → `ALU_Out`=0, `z`=1, `coutfin`=1. A=`FFFFFFFF`, B=`00000001`, ADD → `ALU_Out`=0, `z`=1, `coutfin`=1.
- Compare and shift:
  - A=`FFFFFFFF`, B=`00000001`: SLT → 1; SLTU → 0.
  - With `ALU_SHIFT_EN` defined, A=`80000000`, B=4: SRA → `F8000000`; SRL → `08000000`.
